kmul_issue_ctrl: RTL and testbench
==================================

Name: kmul_issue_ctrl

Overview:
- Front-end issue controller sitting directly upstream of karatsuba64.
- Buffers 64x64 operand pairs from a valid/ready stream in a small FIFO and issues each pair to the multiplier with a one-cycle start pulse.
- Waits for the multiplier's valid_out, captures the 128-bit product and presents it on a valid/ready result port.
- Exactly one multiplication is in flight at a time.

Parameters:
- DEPTH, 4: operand FIFO entries; power of two, minimum 2.
- CNT_W, 16: width of the completed-operation counter.
- TIMEOUT_CYCLES, 64: watchdog limit, in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals !full.
- in_a  in  64  operand A.
- in_b  in  64  operand B.
- mul_start  out  1  one-cycle start pulse to karatsuba64.start.
- mul_a  out  64  registered operand A to karatsuba64.A.
- mul_b  out  64  registered operand B to karatsuba64.B.
- mul_p  in  128  karatsuba64.P.
- mul_valid  in  1  karatsuba64.valid_out.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_p  out  128  registered product.
- done_cnt  out  CNT_W  completed results, i.e. out handshakes.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.

Behaviour:
- Reset values: in_ready=1, mul_start=0, mul_a=0, mul_b=0, out_valid=0, out_p=0, done_cnt=0, busy=0. FIFO is emptied and FSM=IDLE.
- Reset asserted mid-operation aborts everything. Any product later driven by the multiplier is ignored until a new ISSUE.
- FIFO: a push occurs when in_valid&&in_ready. Pointers wrap modulo DEPTH, and a count register gives full/empty.
- No bypass: a pair pushed into an empty FIFO is first visible to the FSM on the next cycle.
- Push and pop in the same cycle are legal when the FIFO is neither empty nor full. The count is then unchanged.
- in_ready is low only when the FIFO is full. When full, no push occurs even if a pop happens the same cycle.
- IDLE: if the FIFO is non-empty, pop the head, load mul_a/mul_b and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: mul_start=1 for exactly this one cycle. Then go to GUARD.
- GUARD: one cycle with mul_valid ignored, which masks a stale valid_out level from the previous operation. Then go to WAIT.
- WAIT: on the first cycle mul_valid=1, capture out_p<=mul_p, set out_valid and go to HOLD.
- HOLD: out_valid=1 and out_p stays stable until out_ready=1.
  - On the handshake edge: out_valid<=0, done_cnt increments and wraps at 2^CNT_W, and the FSM goes to IDLE.
  - HOLD to IDLE to ISSUE gives a minimum 1-cycle bubble between operations.
- mul_a/mul_b are stable from ISSUE until the next IDLE pop. They are never modified while in ISSUE, GUARD or WAIT.
- mul_start is never asserted outside ISSUE, and never twice for one pop.
- Latency: pair pushed at edge t into empty FIFO with FSM in IDLE:
  - pop at edge t+1;
  - mul_start high during the cycle following edge t+1;
  - result visible one cycle after mul_valid is sampled in WAIT.
- in_a/in_b may change freely after the push handshake.
- Results are delivered in push order. No pair is dropped or duplicated.

Optional Feature:
- Macro: KMUL_ISSUE_TIMEOUT_EN.
- With the macro defined:
  - Adds output port timeout_err (1 bit, reset 0).
  - A counter runs in WAIT. If mul_valid has not been seen after TIMEOUT_CYCLES cycles in WAIT, the FSM drops the operation, goes to IDLE and sets timeout_err sticky.
  - out_valid is not raised for the dropped pair, and done_cnt does not increment.
  - timeout_err clears only on rst.
- Without the macro: no timeout_err port and no counter. WAIT waits indefinitely.

Test Plan:
- Single op: push A=0x2, B=0x3 with out_ready=1, DUT wired to karatsuba64 → exactly one mul_start pulse; out_p=0x6; done_cnt=1; busy returns to 0.
- Back-to-back: push four pairs (0xFFFF_FFFF_FFFF_FFFF x 1), (all-ones x all-ones), (0x8000_0000_0000_0000 x 2), (0xAAAA…AA x 0x5555…55) on consecutive cycles → in_ready stays 1 through the 4th push, fifth push blocked (in_ready=0), results match the reference product in order, done_cnt=4.
- Backpressure: out_ready=0 for 20 cycles after out_valid → out_p stable, no new mul_start; release gives one handshake, then the next op issues.
- Stale valid: model multiplier holding mul_valid=1 from the previous op through the next ISSUE and GUARD → the new result is not captured until a fresh mul_valid in WAIT; no duplicate output.
- Reset mid-op: assert rst during WAIT with 2 pairs queued → all outputs reach reset values immediately; a late mul_valid after release produces no out_valid.
- KMUL_ISSUE_TIMEOUT_EN with TIMEOUT_CYCLES=8, stub never asserting mul_valid → timeout_err=1 after 8 WAIT cycles, FSM to IDLE, next queued pair issues, done_cnt unchanged.

Source files
------------

// File: rtl/kmul_issue_ctrl.sv
// kmul_issue_ctrl: operand FIFO plus a single-in-flight issue FSM in front of karatsuba64.
// Define KMUL_ISSUE_TIMEOUT_EN to add the WAIT-state watchdog and the sticky timeout_err output.
module kmul_issue_ctrl #(
  parameter int DEPTH          = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_a,
  input  logic [63:0]       in_b,
  output logic              mul_start,
  output logic [63:0]       mul_a,
  output logic [63:0]       mul_b,
  input  logic [127:0]      mul_p,
  input  logic              mul_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_p,
  output logic [CNT_W-1:0]  done_cnt,
`ifdef KMUL_ISSUE_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAIT,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [63:0]      fifo_a [DEPTH];
  logic [63:0]      fifo_b [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             capture;
  logic             retire;
  logic             timeout_hit;

  // Pointer wrap relies on DEPTH being a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("kmul_issue_ctrl: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  assign full     = (occ == OCC_W'(DEPTH));
  assign empty    = (occ == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after its push has advanced occ.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = GUARD;
      GUARD:   state_nxt = WAIT;
      WAIT: begin
        if (mul_valid) begin
          state_nxt = HOLD;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_start = (state == ISSUE);
    out_valid = (state == HOLD);
    pop       = (state == IDLE) && !empty;
    capture   = (state == WAIT) && mul_valid;
    retire    = (state == HOLD) && out_ready;
    busy      = (state != IDLE) || !empty;
  end

  // Operands only change on a pop, so they stay put from ISSUE through HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a    <= '0;
      mul_b    <= '0;
      out_p    <= '0;
      done_cnt <= '0;
    end else begin
      if (pop) begin
        mul_a <= fifo_a[rd_ptr];
        mul_b <= fifo_b[rd_ptr];
      end
      if (capture) begin
        out_p <= mul_p;
      end
      if (retire) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
    end
  end

`ifdef KMUL_ISSUE_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] wait_cnt;

  // A product arriving on the last allowed WAIT cycle still wins over the timeout.
  assign timeout_hit = (state == WAIT) && !mul_valid &&
                       (wait_cnt == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != WAIT) begin
        wait_cnt <= '0;
      end else if (!mul_valid) begin
        wait_cnt <= wait_cnt + TMR_W'(1);
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_kmul_issue_ctrl.sv
// Randomized and directed bench for kmul_issue_ctrl with a behavioural multiplier stub.
// The reference model tracks pushed pairs and expected products in queues, in push order.
`timescale 1ns/1ps
module tb_kmul_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int TMO   = 8;

  typedef enum int {STUB_NORMAL, STUB_STALE, STUB_DEAD} stub_mode_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_a;
  logic [63:0]       in_b;
  logic              mul_start;
  logic [63:0]       mul_a;
  logic [63:0]       mul_b;
  logic [127:0]      mul_p;
  logic              mul_valid;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_p;
  logic [CNT_W-1:0]  done_cnt;
  logic              busy;
`ifdef KMUL_ISSUE_TIMEOUT_EN
  logic              timeout_err;
`endif

  int                n_cmp = 0;
  int                n_bad = 0;
  int                n_starts = 0;
  int                n_outs = 0;
  logic [127:0]      last_out = '0;
  logic [CNT_W-1:0]  exp_done = '0;
  logic [127:0]      pend_q[$];
  logic [127:0]      res_q[$];
  stub_mode_t        stub_mode = STUB_NORMAL;
  int                stub_lat = 3;
  bit                rand_ready = 1'b0;

  kmul_issue_ctrl #(
    .DEPTH          (DEPTH),
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_p       (mul_p),
    .mul_valid   (mul_valid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_p       (out_p),
    .done_cnt    (done_cnt),
`ifdef KMUL_ISSUE_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Multiplier stub: answers stub_lat cycles after GUARD; STALE keeps valid high until the next WAIT.
  initial begin
    int         cyc = 0;
    int         due = -1;
    int         start_cyc = -100;
    bit         pending = 1'b0;
    logic [127:0] s_p = '0;
    mul_valid = 1'b0;
    mul_p     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mul_start && !rst) begin
        s_p       = 128'(mul_a) * 128'(mul_b);
        start_cyc = cyc;
        pending   = (stub_mode != STUB_DEAD);
        due       = cyc + 1 + stub_lat;
      end
      if (pending && cyc == due) begin
        mul_valid = 1'b1;
        mul_p     = s_p;
        pending   = 1'b0;
      end else if (stub_mode == STUB_STALE) begin
        if (cyc == start_cyc + 2) mul_valid = 1'b0;
      end else begin
        mul_valid = 1'b0;
        mul_p     = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Reference model and scoreboard, sampled mid-cycle.
  initial begin
    logic [127:0] pair;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("done_cnt", 128'(done_cnt), 128'(exp_done));
        if (mul_start) begin
          n_starts++;
          checkOutput("one_in_flight", 128'(res_q.size()), 128'(0));
          if (pend_q.size() == 0) begin
            checkOutput("start_without_pair", 128'(mul_start), 128'(0));
          end else begin
            pair = pend_q.pop_front();
            checkOutput("issue_a", 128'(mul_a), 128'(pair[127:64]));
            checkOutput("issue_b", 128'(mul_b), 128'(pair[63:0]));
            if (stub_mode != STUB_DEAD) res_q.push_back(128'(pair[127:64]) * 128'(pair[63:0]));
          end
        end
        checkOutput("in_ready", 128'(in_ready), 128'(pend_q.size() < DEPTH));
        if (out_valid) begin
          if (res_q.size() == 0) begin
            checkOutput("spurious_out_valid", 128'(out_valid), 128'(0));
          end else begin
            checkOutput("out_p", out_p, res_q[0]);
            last_out = out_p;
            if (out_ready) begin
              void'(res_q.pop_front());
              exp_done = exp_done + CNT_W'(1);
              n_outs++;
            end
          end
        end
        if (in_valid && in_ready) pend_q.push_back({in_a, in_b});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  function automatic logic [63:0] randVal();
    case ($urandom_range(0, 4))
      0:       randVal = '1;
      1:       randVal = '0;
      2:       randVal = 64'd1 << $urandom_range(0, 63);
      default: randVal = {$urandom, $urandom};
    endcase
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    checkOutput({tag, "_mul_start"}, 128'(mul_start), 128'(0));
    checkOutput({tag, "_mul_a"}, 128'(mul_a), 128'(0));
    checkOutput({tag, "_mul_b"}, 128'(mul_b), 128'(0));
    checkOutput({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    checkOutput({tag, "_out_p"}, out_p, 128'(0));
    checkOutput({tag, "_done_cnt"}, 128'(done_cnt), 128'(0));
    checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
`ifdef KMUL_ISSUE_TIMEOUT_EN
    checkOutput({tag, "_timeout_err"}, 128'(timeout_err), 128'(0));
`endif
  endtask

  // Asserts rst asynchronously mid-cycle and returns aligned just after a rising edge.
  task automatic resetDut(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    pend_q.delete();
    res_q.delete();
    exp_done = '0;
    #1;
    checkResetValues(tag);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Must be called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b);
    int guard = 0;
    bit took = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!took && guard < 300) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!took) checkOutput("push_timeout", 128'(in_ready), 128'(1));
    in_valid = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      done = !busy && !out_valid && pend_q.size() == 0 && res_q.size() == 0;
    end
    if (!done) checkOutput("drain_timeout", 128'(busy), 128'(0));
  endtask

  task automatic waitOutValid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) checkOutput("out_valid_timeout", 128'(out_valid), 128'(1));
  endtask

  // Returns at the falling edge of the cycle in which mul_start is high.
  task automatic waitStart(input int budget);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = mul_start;
    end
    if (!seen) checkOutput("start_timeout", 128'(mul_start), 128'(1));
  endtask

  initial begin
    int s0;
    int o0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    resetDut("por");

    // Single op with exact latency.
    out_ready = 1'b1;
    stub_mode = STUB_NORMAL;
    stub_lat  = 3;
    s0 = n_starts;
    applyStimulus(64'h2, 64'h3);
    @(negedge clk);
    checkOutput("lat_no_bypass", 128'(mul_start), 128'(0));
    checkOutput("lat_busy", 128'(busy), 128'(1));
    @(negedge clk);
    checkOutput("lat_start", 128'(mul_start), 128'(1));
    checkOutput("lat_mul_a", 128'(mul_a), 128'(2));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("lat_early_out", 128'(out_valid), 128'(0));
      checkOutput("lat_single_start", 128'(mul_start), 128'(0));
    end
    @(negedge clk);
    checkOutput("lat_out_valid", 128'(out_valid), 128'(1));
    checkOutput("single_out_p", out_p, 128'h6);
    waitIdle(50);
    checkOutput("single_starts", 128'(n_starts - s0), 128'(1));
    checkOutput("single_done", 128'(done_cnt), 128'(1));
    checkOutput("single_busy", 128'(busy), 128'(0));

    // Back-to-back pushes fill the FIFO behind an op parked in HOLD.
    resetDut("b2b");
    out_ready = 1'b0;
    stub_lat  = 2;
    s0 = n_starts;
    applyStimulus(64'h7, 64'h9);
    waitOutValid(50);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(64'h8000_0000_0000_0000, 64'h2);
    applyStimulus(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    in_valid = 1'b1;
    in_a = 64'd12345;
    in_b = 64'd678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("fifth_blocked", 128'(in_ready), 128'(0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(64'd12345, 64'd678);
    waitIdle(200);
    checkOutput("b2b_done", 128'(done_cnt), 128'(6));
    checkOutput("b2b_starts", 128'(n_starts - s0), 128'(6));
    checkOutput("b2b_last", last_out, 128'd8369910);

    // Backpressure: result held for 20 cycles, nothing new issues.
    resetDut("bp");
    out_ready = 1'b0;
    stub_lat  = 4;
    s0 = n_starts;
    applyStimulus(64'h1234_5678, 64'h10);
    applyStimulus(64'h3, 64'h5);
    waitOutValid(50);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("bp_out_p_stable", out_p, 128'h1_2345_6780);
      checkOutput("bp_out_valid", 128'(out_valid), 128'(1));
    end
    checkOutput("bp_no_new_start", 128'(n_starts - s0), 128'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    waitStart(20);
    checkOutput("bp_one_handshake", 128'(done_cnt), 128'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitIdle(100);
    checkOutput("bp_done", 128'(done_cnt), 128'(2));
    checkOutput("bp_last", last_out, 128'hF);

    // Stale valid level held across ISSUE and GUARD.
    resetDut("stale");
    stub_mode = STUB_STALE;
    stub_lat  = 3;
    o0 = n_outs;
    for (int k = 0; k < 4; k++) applyStimulus(randVal(), randVal());
    waitIdle(200);
    checkOutput("stale_outs", 128'(n_outs - o0), 128'(4));
    checkOutput("stale_done", 128'(done_cnt), 128'(4));
    stub_mode = STUB_NORMAL;

    // Reset during WAIT with two pairs queued; the late product must be ignored.
    resetDut("pre_abort");
    stub_lat = 2;
    applyStimulus(64'h55, 64'h66);
    waitIdle(50);
    checkOutput("pre_abort_done", 128'(done_cnt), 128'(1));
    stub_lat = 6;
    applyStimulus(64'hDEAD_BEEF, 64'h1111);
    applyStimulus(64'h2, 64'h2);
    applyStimulus(64'h4, 64'h4);
    waitStart(20);
    repeat (2) @(negedge clk);
    s0 = n_starts;
    resetDut("abort");
    repeat (12) @(posedge clk);
    #1;
    checkOutput("abort_out_valid", 128'(out_valid), 128'(0));
    checkOutput("abort_busy", 128'(busy), 128'(0));
    checkOutput("abort_no_start", 128'(n_starts - s0), 128'(0));
    checkOutput("abort_done", 128'(done_cnt), 128'(0));

`ifdef KMUL_ISSUE_TIMEOUT_EN
    // Watchdog: the stub never answers.
    resetDut("tmo_pre");
    stub_mode = STUB_DEAD;
    out_ready = 1'b1;
    applyStimulus(64'h11, 64'h22);
    applyStimulus(64'h33, 64'h44);
    waitStart(20);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checkOutput("tmo_no_restart", 128'(mul_start), 128'(0));
    end
    checkOutput("tmo_not_yet", 128'(timeout_err), 128'(0));
    @(negedge clk);
    checkOutput("tmo_err_set", 128'(timeout_err), 128'(1));
    checkOutput("tmo_idle_no_start", 128'(mul_start), 128'(0));
    @(negedge clk);
    checkOutput("tmo_next_issue", 128'(mul_start), 128'(1));
    waitIdle(100);
    checkOutput("tmo_done", 128'(done_cnt), 128'(0));
    checkOutput("tmo_sticky", 128'(timeout_err), 128'(1));
    stub_mode = STUB_NORMAL;
`endif

    // Randomized traffic with random backpressure; done_cnt wraps at 16.
    resetDut("rand");
    o0 = n_outs;
    rand_ready = 1'b1;
    for (int batch = 0; batch < 6; batch++) begin
      stub_mode = (batch % 2 == 1) ? STUB_STALE : STUB_NORMAL;
      stub_lat  = $urandom_range(2, 5);
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        applyStimulus(randVal(), randVal());
      end
      waitIdle(2000);
    end
    rand_ready = 1'b0;
    stub_mode  = STUB_NORMAL;
    checkOutput("rand_outs", 128'(n_outs - o0), 128'(48));
    checkOutput("rand_done_wrap", 128'(done_cnt), 128'(48 % 16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
